// File: rtl/seq_arith_8b_sub_accum.sv
// Block accumulator placed after the 8-bit subtractor.
// It sums NSAMPLES signed differences into a 16-bit total and counts the
// negative ones. Each block result is held on a val/rdy port until the
// consumer accepts it.
//
// state | meaning
// ------+------------------------------------------------------------
// ACC   | accepting differences (in_rdy=1), accumulating sum/neg/cnt
// OUT   | block complete, result presented (out_val=1) until accepted
module seq_arith_8b_sub_accum #(
  parameter int NSAMPLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [7:0]  in_diff,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [15:0] out_sum,
  output logic [7:0]  out_neg
);

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(NSAMPLES - 1);

  state_t      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  neg_q, neg_d;
  logic [7:0]  cnt_q, cnt_d;

  logic in_xfer;
  logic out_xfer;
  logic last_sample;

  // Handshakes use the registered state only, so no input feeds back to a ready/valid.
  assign in_xfer     = in_val && in_rdy;
  assign out_xfer    = out_val && out_rdy;
  assign last_sample = (cnt_q == LAST_CNT);

  // State and datapath registers, cleared synchronously.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACC;
      sum_q   <= '0;
      neg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath updates: accumulate in ACC, clear on result hand-off.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_ACC: begin
        if (in_xfer) begin
          sum_d = sum_q + {{8{in_diff[7]}}, in_diff};
          neg_d = neg_q + {7'b0, in_diff[7]};
          if (last_sample) begin
            cnt_d   = '0;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_OUT: begin
        if (out_xfer) begin
          sum_d   = '0;
          neg_d   = '0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // Outputs: handshake flags from state (forced low in reset), data straight from registers.
  always_comb begin
    in_rdy  = !reset && (state_q == S_ACC);
    out_val = !reset && (state_q == S_OUT);
    out_sum = sum_q;
    out_neg = neg_q;
  end

endmodule

// File: tb/tb_seq_arith_8b_sub_accum.sv
// Bench for seq_arith_8b_sub_accum: directed scenarios plus random traffic,
// checked every cycle against a block-level reference model.
module tb_seq_arith_8b_sub_accum;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_val = 1'b0;
  logic [7:0]  in_diff = 8'h00;
  logic        out_rdy = 1'b0;
  logic        in_rdy;
  logic        out_val;
  logic [15:0] out_sum;
  logic [7:0]  out_neg;

  seq_arith_8b_sub_accum #(.NSAMPLES(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_diff (in_diff),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_sum (out_sum),
    .out_neg (out_neg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: samples of the block in progress, and the pending result.
  int blk[$];
  bit have_res = 1'b0;
  int exp_sum  = 0;
  int exp_neg  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle: drive inputs after the rising edge, check at the falling
  // edge, then advance the model by what the next rising edge will do.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic o);
    logic [15:0] es;
    @(posedge clk);
    #1;
    reset   = r;
    in_val  = v;
    in_diff = d;
    out_rdy = o;
    @(negedge clk);
    check("in_rdy",  32'(in_rdy),  32'(!r && !have_res));
    check("out_val", 32'(out_val), 32'(!r && have_res));
    if (!r && have_res) begin
      es = exp_sum[15:0];
      check("out_sum", 32'(out_sum), 32'(es));
      check("out_neg", 32'(out_neg), 32'(exp_neg));
    end
    if (r) begin
      blk.delete();
      have_res = 1'b0;
    end else if (have_res) begin
      if (o) have_res = 1'b0;
    end else if (v) begin
      blk.push_back(int'($signed(d)));
      if (blk.size() == N) begin
        exp_sum = 0;
        exp_neg = 0;
        foreach (blk[i]) begin
          exp_sum += blk[i];
          if (blk[i] < 0) exp_neg++;
        end
        have_res = 1'b1;
        blk.delete();
      end
    end
  endtask

  task automatic feed(input logic [7:0] d);
    cyc(1'b0, 1'b1, d, 1'b1);
  endtask

  task automatic idle(input logic o);
    cyc(1'b0, 1'b0, 8'h00, o);
  endtask

  initial begin
    // Reset held for two cycles, then released.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1'b1);

    // Positive block.
    feed(8'd3); feed(8'd5); feed(8'd7); feed(8'd1);
    idle(1'b1);
    check("pos_sum", 32'(out_sum), 32'd16);
    check("pos_neg", 32'(out_neg), 32'd0);
    idle(1'b1);

    // Signed mix.
    feed(8'hFF); feed(8'h80); feed(8'h01); feed(8'h7F);
    idle(1'b1);
    check("mix_sum", 32'(out_sum), 32'h0000FFFF);
    check("mix_neg", 32'(out_neg), 32'd2);

    // Extremes with backpressure and a stray in_val pulse.
    feed(8'h80); feed(8'h80); feed(8'h80); feed(8'h80);
    idle(1'b0);
    check("ext_sum0", 32'(out_sum), 32'h0000FE00);
    check("ext_neg0", 32'(out_neg), 32'd4);
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    check("ext_rdy_stall", 32'(in_rdy), 32'd0);
    idle(1'b0);
    check("ext_sum2", 32'(out_sum), 32'h0000FE00);
    idle(1'b1);
    idle(1'b1);
    check("ext_back_acc", 32'(in_rdy), 32'd1);

    // Input gaps.
    feed(8'd10); idle(1'b1); idle(1'b1);
    feed(8'd20); idle(1'b1);
    feed(8'd30); feed(8'd40);
    idle(1'b1);
    check("gap_val", 32'(out_val), 32'd1);
    check("gap_sum", 32'(out_sum), 32'd100);

    // Reset mid-block discards partial data.
    feed(8'd50); feed(8'd60);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
    idle(1'b1);
    check("rst_sum", 32'(out_sum), 32'd10);
    check("rst_neg", 32'(out_neg), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 9) < 7,
          8'($urandom),
          $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
